// File: rtl/multi_blob_tracker.sv
// Per-channel chroma blob tracker: classifies pixels against chroma and history
// thresholds, accumulates bounding boxes per frame and publishes them at vsync.
module multi_blob_tracker #(
  parameter int NUM_CH = 2,
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int HIST_W = 4,
  parameter int CNT_W  = 19,
  localparam int HC_W  = $clog2(HIST_W + 1),
  localparam int PC_W  = $clog2(NUM_CH + 1),
  localparam int RD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vga_vs,
  input  logic                     pix_valid,
  input  logic [X_W-1:0]           pix_x,
  input  logic [Y_W-1:0]           pix_y,
  input  logic [18:0]              pix_addr,
  input  logic [7:0]               cb,
  input  logic [7:0]               cr,
  input  logic [NUM_CH*8-1:0]      thr_cb,
  input  logic [NUM_CH*8-1:0]      thr_cr,
  input  logic [NUM_CH*HIST_W-1:0] hist_in,
  input  logic [HC_W-1:0]          hist_thr,
  input  logic [CNT_W-1:0]         min_count,
  output logic [NUM_CH*HIST_W-1:0] hist_out,
  output logic                     hist_we,
  output logic [18:0]              hist_addr,
  output logic [PC_W-1:0]          pix_class,
  output logic                     frame_done,
  input  logic [RD_W-1:0]          rd_ch,
  output logic [X_W-1:0]           rd_xmin,
  output logic [X_W-1:0]           rd_xmax,
  output logic [Y_W-1:0]           rd_ymin,
  output logic [Y_W-1:0]           rd_ymax,
  output logic [CNT_W-1:0]         rd_count,
  output logic                     rd_valid
);

  typedef enum logic {WAIT_FRAME, ACCUM} state_t;

  localparam logic [X_W:0]   H_LIM  = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0]   V_LIM  = (Y_W + 1)'(V_RES);
  localparam logic [X_W-1:0] X_INIT = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_INIT = Y_W'(V_RES - 1);

  state_t state_q, state_d;
  logic   vs_q;
  logic   boundary, accept, publish;

  logic [NUM_CH-1:0]        raw, qual;
  logic [NUM_CH*HIST_W-1:0] hist_nxt;
  logic [HC_W-1:0]          pop;
  logic [PC_W-1:0]          cls;
  logic                     found;

  logic [X_W-1:0]   acc_xmin [NUM_CH];
  logic [X_W-1:0]   acc_xmax [NUM_CH];
  logic [Y_W-1:0]   acc_ymin [NUM_CH];
  logic [Y_W-1:0]   acc_ymax [NUM_CH];
  logic [CNT_W-1:0] acc_cnt  [NUM_CH];
  logic [X_W-1:0]   res_xmin [NUM_CH];
  logic [X_W-1:0]   res_xmax [NUM_CH];
  logic [Y_W-1:0]   res_ymin [NUM_CH];
  logic [Y_W-1:0]   res_ymax [NUM_CH];
  logic [CNT_W-1:0] res_cnt  [NUM_CH];

  assign boundary = vs_q & ~vga_vs;
  assign accept   = pix_valid & ({1'b0, pix_x} < H_LIM) & ({1'b0, pix_y} < V_LIM) & ~boundary;

  always_comb begin
    raw      = '0;
    qual     = '0;
    hist_nxt = '0;
    pop      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pop = '0;
      for (int unsigned b = 0; b < HIST_W; b++)
        pop = pop + HC_W'(hist_in[c*HIST_W + b]);
      raw[c]  = (cb < thr_cb[c*8 +: 8]) && (cr < thr_cr[c*8 +: 8]);
      qual[c] = raw[c] && (pop >= hist_thr);
      hist_nxt[c*HIST_W +: HIST_W] = {hist_in[c*HIST_W +: HIST_W-1], raw[c]};
    end
  end

  // Lowest-index qualified channel wins the class code.
  always_comb begin
    cls   = '0;
    found = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (qual[c] && !found) begin
        cls   = PC_W'(c + 1);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    case (state_q)
      WAIT_FRAME: if (boundary) state_d = ACCUM;
      ACCUM:      if (boundary) publish = 1'b1;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q       <= 1'b0;
      state_q    <= WAIT_FRAME;
      hist_we    <= 1'b0;
      hist_out   <= '0;
      hist_addr  <= '0;
      pix_class  <= '0;
      frame_done <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        acc_xmin[c] <= X_INIT;
        acc_xmax[c] <= '0;
        acc_ymin[c] <= Y_INIT;
        acc_ymax[c] <= '0;
        acc_cnt[c]  <= '0;
        res_xmin[c] <= X_INIT;
        res_xmax[c] <= '0;
        res_ymin[c] <= Y_INIT;
        res_ymax[c] <= '0;
        res_cnt[c]  <= '0;
      end
    end else begin
      vs_q       <= vga_vs;
      state_q    <= state_d;
      hist_we    <= accept;
      pix_class  <= accept ? cls : '0;
      frame_done <= publish;
      if (accept) begin
        hist_out  <= hist_nxt;
        hist_addr <= pix_addr;
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (publish) begin
          res_xmin[c] <= acc_xmin[c];
          res_xmax[c] <= acc_xmax[c];
          res_ymin[c] <= acc_ymin[c];
          res_ymax[c] <= acc_ymax[c];
          res_cnt[c]  <= acc_cnt[c];
          acc_xmin[c] <= X_INIT;
          acc_xmax[c] <= '0;
          acc_ymin[c] <= Y_INIT;
          acc_ymax[c] <= '0;
          acc_cnt[c]  <= '0;
        end else if (state_q == ACCUM && accept && qual[c]) begin
          if (pix_x < acc_xmin[c]) acc_xmin[c] <= pix_x;
          if (pix_x > acc_xmax[c]) acc_xmax[c] <= pix_x;
          if (pix_y < acc_ymin[c]) acc_ymin[c] <= pix_y;
          if (pix_y > acc_ymax[c]) acc_ymax[c] <= pix_y;
          if (acc_cnt[c] != '1) acc_cnt[c] <= acc_cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_xmin  = X_INIT;
    rd_xmax  = '0;
    rd_ymin  = Y_INIT;
    rd_ymax  = '0;
    rd_count = '0;
    if (32'(rd_ch) < 32'(NUM_CH)) begin
      rd_xmin  = res_xmin[rd_ch];
      rd_xmax  = res_xmax[rd_ch];
      rd_ymin  = res_ymin[rd_ch];
      rd_ymax  = res_ymax[rd_ch];
      rd_count = res_cnt[rd_ch];
    end
    rd_valid = (rd_count >= min_count) && (rd_count != '0);
  end

endmodule
